memory_dumper: RTL and testbench
================================

# memory_dumper

UART readback engine for the 4-bit CPU. On a start request it reads every register of `reg_memory` in address order, packs two 4-bit registers per byte, and serialises each byte on a single UART line as 8N1, LSB first. It is the transmit-side counterpart of the programmer's UART receive path. A host can verify a program by dumping the memory and comparing the stream against the image it sent. It sits beside `programmer` in `cpu` and shares the memory read port.

## Interface

Parameters:
- `CLKS_PER_BIT`, 521: clock cycles per UART bit. Matches the programmer's receive bit period. Must be ≥ 2.
- `REGISTER_WIDTH`, 4: width of one memory register. Fixed at 4; two registers make one byte.
- `MEMORY_ADDRESS_WIDTH`, 4: width of `mem_addr_o`.
- `MEMORY_REGISTERS`, 16: number of registers dumped. Must be even and ≤ 2^`MEMORY_ADDRESS_WIDTH`.

Ports:
- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `reset_i`  in  1  reset; synchronous, active-high.
- `dump_i`  in  1  start request, level-sampled. Honoured only in IDLE.
- `mem_addr_o`  out  `MEMORY_ADDRESS_WIDTH`  memory read address, registered.
- `mem_data_i`  in  `REGISTER_WIDTH`  combinational read data of `reg_memory` at `mem_addr_o`.
- `tx_o`  out  1  UART line, registered. Idles high.
- `busy_o`  out  1  high from leaving IDLE until the last stop bit completes.
- `done_o`  out  1  single-cycle pulse on completion of the dump.

## Operation

- Byte k, for k = 0 … `MEMORY_REGISTERS`/2−1, is {mem[2k], mem[2k+1]}. The even address is the high nibble, which matches the programmer's load order. Bytes go out in increasing k.
- Frame format: start bit 0, data bits b0..b7 (LSB first), stop bit 1. Every bit lasts exactly `CLKS_PER_BIT` cycles. No parity.
- FSM states and transitions:
  - IDLE: `tx_o`=1, `mem_addr_o`=0. If `dump_i`=1, go to FETCH_HI.
  - FETCH_HI: `mem_addr_o`=2k. Latch `mem_data_i` into shift[7:4]. Set `mem_addr_o`=2k+1. Go to FETCH_LO.
  - FETCH_LO: latch `mem_data_i` into shift[3:0]. Go to START and drive `tx_o`=0.
  - START: run `CLKS_PER_BIT` cycles, then go to DATA and drive `tx_o`=shift[0].
  - DATA: every `CLKS_PER_BIT` cycles, shift right and advance the bit counter (0…7). After bit 7 completes, go to STOP and drive `tx_o`=1.
  - STOP: after `CLKS_PER_BIT` cycles:
    - If k is the last byte: go to IDLE and pulse `done_o`.
    - Otherwise: k←k+1, set `mem_addr_o`=2k, go to FETCH_HI.
- Baud counter: counts 0 … `CLKS_PER_BIT`−1 and wraps at each bit boundary. It is cleared on entry to START.
- `dump_i` is ignored while `busy_o`=1; it is neither queued nor restarted. If `dump_i` is still high when the FSM returns to IDLE, a new dump starts immediately.
- The byte index wraps from the last byte back to 0 only via IDLE.
- Reset mid-frame: on the reset edge, `tx_o`=1, FSM=IDLE, all counters and `mem_addr_o`=0, `busy_o`=0, `done_o`=0. The truncated frame is abandoned with no stop-bit completion.
- Mutual exclusion with the programmer while it is writing is enforced in `cpu`, which gates `dump_i` with `p_programm_i`. The block itself does not check for it.

## Timing

- Reset values: `tx_o`=1, `mem_addr_o`=0, `busy_o`=0, `done_o`=0.
- Let E0 be the edge that samples `dump_i`=1 in IDLE.
  - `busy_o` rises at E0.
  - `tx_o` falls at E0+3 (IDLE→FETCH_HI→FETCH_LO→START).
- Per byte, `tx_o` is driven for 10·`CLKS_PER_BIT` cycles. Between the stop bit of byte k and the start bit of byte k+1 there are 2 extra high cycles (FETCH_HI, FETCH_LO).
- Full dump duration, from E0 to `done_o`: 3 + N·10·`CLKS_PER_BIT` + (N−1)·2 cycles, with N = `MEMORY_REGISTERS`/2.
- `done_o` is high for exactly one cycle, on the same edge that `busy_o` falls.

## Test plan

- Reset: hold `reset_i` for 10 cycles → `tx_o`=1, `busy_o`=0, `done_o`=0, `mem_addr_o`=0. Assert `dump_i` during reset → no frame starts.
- Single byte (`CLKS_PER_BIT`=4, `MEMORY_REGISTERS`=2, mem[0]=0xD, mem[1]=0xE):
  - Pulse `dump_i` → `tx_o` falls exactly 3 edges later.
  - Line carries 0,0,1,1,1,1,0,1,1,1, i.e. byte 0xDE, each level held 4 cycles.
  - `done_o` pulses once, at cycle 43.
- Full dump (`CLKS_PER_BIT`=4, 16 registers, mem[i]=i) → bytes 0x01, 0x23, 0x45, 0x67, 0x89, 0xAB, 0xCD, 0xEF, with 2-cycle high gaps. `mem_addr_o` sequence is 0..15. Total 3+320+14=337 cycles.
- Loopback: `tx_o` → `uart_rx` (`CLKS_PER_BIT`=521), memory loaded with a known program → received bytes equal the loaded image.
- Busy/retrigger: toggle `dump_i` during byte 3 → stream unchanged, exactly one `done_o`. Hold `dump_i` high continuously → a second dump starts on the edge after `done_o`.
- Reset mid-data-bit of byte 2 → `tx_o`=1 on the next edge, `busy_o`=0, no `done_o`. A subsequent dump restarts from address 0.

Source files
------------

// File: rtl/memory_dumper.sv
// ---------------------------------------------------------------------------
// memory_dumper
//
// UART readback engine for the 4-bit CPU. On a start request it walks every
// register of reg_memory in address order, packs two registers per byte
// (even address in the high nibble) and sends each byte as an 8N1 frame,
// LSB first, on a single idle-high line.
//
// Ports
//   clk_i       system clock, all state changes on its rising edge
//   reset_i     synchronous active-high reset
//   dump_i      start request, level-sampled, only honoured while idle
//   mem_addr_o  registered read address into reg_memory
//   mem_data_i  combinational read data of reg_memory at mem_addr_o
//   tx_o        registered UART line, idles high
//   busy_o      high from leaving idle until the last stop bit completes
//   done_o      one-cycle pulse when the whole dump has been sent
// ---------------------------------------------------------------------------
module memory_dumper #(
    parameter int CLKS_PER_BIT         = 521,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            dump_i,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
    input  logic [REGISTER_WIDTH-1:0]       mem_data_i,
    output logic                            tx_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int BYTE_WIDTH = 2 * REGISTER_WIDTH;
    localparam int NUM_BYTES  = MEMORY_REGISTERS / 2;
    localparam int BAUD_WIDTH = $clog2(CLKS_PER_BIT);
    localparam int BIT_WIDTH  = $clog2(BYTE_WIDTH);
    localparam int AW         = MEMORY_ADDRESS_WIDTH;

    localparam logic [BAUD_WIDTH-1:0] BAUD_LAST = BAUD_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_WIDTH-1:0] BAUD_ONE  = BAUD_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0]  BIT_LAST  = BIT_WIDTH'(BYTE_WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0]  BIT_ONE   = BIT_WIDTH'(1);
    localparam logic [AW-1:0]         LAST_BYTE = AW'(NUM_BYTES - 1);
    localparam logic [AW-1:0]         ADDR_ONE  = AW'(1);

    // FSM encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH_HI = 3'd1;
    localparam logic [2:0] ST_FETCH_LO = 3'd2;
    localparam logic [2:0] ST_START    = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;
    localparam logic [2:0] ST_STOP     = 3'd5;

    logic [2:0]            state_q,      state_d;
    logic [BAUD_WIDTH-1:0] baud_q,       baud_d;
    logic [BIT_WIDTH-1:0]  bitCnt_q,     bitCnt_d;
    logic [BYTE_WIDTH-1:0] shift_q,      shift_d;
    logic [AW-1:0]         byteIdx_q,    byteIdx_d;
    logic [AW-1:0]         addr_q,       addr_d;
    logic                  tx_q,         tx_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic                  firstFetch_q, firstFetch_d;

    logic bitTick;

    // A bit period ends when the baud counter sits on its last value.
    assign bitTick = (baud_q == BAUD_LAST);

    // Next-state logic for the whole engine. Every register holds its value
    // unless a state below says otherwise; done_o is a pulse so it defaults
    // low every cycle.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bitCnt_d     = bitCnt_q;
        shift_d      = shift_q;
        byteIdx_d    = byteIdx_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        firstFetch_d = firstFetch_q;

        case (state_q)
            ST_IDLE: begin
                tx_d      = 1'b1;
                addr_d    = '0;
                baud_d    = '0;
                bitCnt_d  = '0;
                byteIdx_d = '0;
                busy_d    = 1'b0;
                if (dump_i) begin
                    state_d      = ST_FETCH_HI;
                    busy_d       = 1'b1;
                    firstFetch_d = 1'b1;
                end
            end

            // The first fetch of a dump spends one extra cycle here. That
            // gives the three-cycle lead from the start request to the
            // first start bit while the gap between consecutive frames
            // stays at two cycles.
            ST_FETCH_HI: begin
                if (firstFetch_q) begin
                    firstFetch_d = 1'b0;
                end else begin
                    shift_d[BYTE_WIDTH-1 -: REGISTER_WIDTH] = mem_data_i;
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = ST_FETCH_LO;
                end
            end

            ST_FETCH_LO: begin
                shift_d[REGISTER_WIDTH-1:0] = mem_data_i;
                state_d = ST_START;
                tx_d    = 1'b0;
                baud_d  = '0;
            end

            ST_START: begin
                if (bitTick) begin
                    baud_d   = '0;
                    bitCnt_d = '0;
                    tx_d     = shift_q[0];
                    state_d  = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            // The line already shows shift_q[0]; at a bit boundary the next
            // data bit is shift_q[1], which becomes bit 0 after the shift.
            ST_DATA: begin
                if (bitTick) begin
                    baud_d = '0;
                    if (bitCnt_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d  = shift_q >> 1;
                        tx_d     = shift_q[1];
                        bitCnt_d = bitCnt_q + BIT_ONE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            // addr_q still holds the odd address 2k+1 of the byte just sent,
            // so one increment lands on 2(k+1).
            ST_STOP: begin
                if (bitTick) begin
                    baud_d = '0;
                    if (byteIdx_q == LAST_BYTE) begin
                        state_d   = ST_IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        addr_d    = '0;
                        byteIdx_d = '0;
                    end else begin
                        byteIdx_d = byteIdx_q + ADDR_ONE;
                        addr_d    = addr_q + ADDR_ONE;
                        state_d   = ST_FETCH_HI;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                addr_d  = '0;
            end
        endcase
    end

    // State registers. Reset abandons any frame in flight and returns the
    // line to idle-high immediately.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            baud_q       <= '0;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            byteIdx_q    <= '0;
            addr_q       <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            firstFetch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            byteIdx_q    <= byteIdx_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            firstFetch_q <= firstFetch_d;
        end
    end

    assign mem_addr_o = addr_q;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_memory_dumper.sv
// ---------------------------------------------------------------------------
// tb_memory_dumper
//
// Self-checking bench for memory_dumper with a short bit period. The memory
// is a plain array read combinationally at mem_addr_o. Expected line
// waveforms are built from the frame rules (lead-in, 8N1 frames, inter-byte
// gaps) and the byte packing, then compared sample by sample.
// ---------------------------------------------------------------------------
module tb_memory_dumper;

    localparam int CPB    = 4;
    localparam int RW     = 4;
    localparam int AW     = 4;
    localparam int NREG   = 16;
    localparam int NBYTES = NREG / 2;
    localparam int T      = 3 + NBYTES * 10 * CPB + (NBYTES - 1) * 2;
    localparam int LOGLEN = 2 * T + 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          dump  = 1'b0;
    logic [AW-1:0] memAddr;
    logic [RW-1:0] memData;
    logic          tx;
    logic          busy;
    logic          done;

    logic [RW-1:0] mem [NREG];

    int checks   = 0;
    int failures = 0;

    logic          lineLog [LOGLEN];
    logic          busyLog [LOGLEN];
    logic          doneLog [LOGLEN];
    logic [AW-1:0] addrLog [LOGLEN];

    logic          expLine  [LOGLEN];
    logic [7:0]    expBytes [NBYTES];
    logic [7:0]    gotBytes [NBYTES];

    memory_dumper #(
        .CLKS_PER_BIT         (CPB),
        .REGISTER_WIDTH       (RW),
        .MEMORY_ADDRESS_WIDTH (AW),
        .MEMORY_REGISTERS     (NREG)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .dump_i     (dump),
        .mem_addr_o (memAddr),
        .mem_data_i (memData),
        .tx_o       (tx),
        .busy_o     (busy),
        .done_o     (done)
    );

    assign memData = mem[memAddr];

    always #5 clk = ~clk;

    // Advance one clock; we sit on the falling edge afterwards, safely away
    // from the edge where the DUT updates.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < NREG; i++) mem[i] = RW'($urandom_range(0, 15));
    endtask

    // Reference: bytes are {mem[2k], mem[2k+1]}; the line shows 3 idle-high
    // samples, then per byte a start bit, 8 data bits LSB first and a stop
    // bit, each CPB samples, with 2 high samples between frames.
    task automatic build_model();
        int idx;
        idx = 0;
        for (int k = 0; k < NBYTES; k++) expBytes[k] = {mem[2*k], mem[2*k+1]};
        for (int i = 0; i < 3; i++) begin expLine[idx] = 1'b1; idx++; end
        for (int k = 0; k < NBYTES; k++) begin
            for (int c = 0; c < CPB; c++) begin expLine[idx] = 1'b0; idx++; end
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < CPB; c++) begin expLine[idx] = expBytes[k][b]; idx++; end
            for (int c = 0; c < CPB; c++) begin expLine[idx] = 1'b1; idx++; end
            if (k < NBYTES - 1)
                for (int c = 0; c < 2; c++) begin expLine[idx] = 1'b1; idx++; end
        end
        expLine[idx] = 1'b1;
    endtask

    // Sample j is taken after the j-th edge counted from the edge that
    // accepts the request. dump must already be set by the caller.
    task automatic record_dump(input int nSamples, input bit hold, input int togLo, input int togHi);
        for (int j = 0; j < nSamples; j++) begin
            step();
            lineLog[j] = tx;
            busyLog[j] = busy;
            doneLog[j] = done;
            addrLog[j] = memAddr;
            if (hold)                          dump = 1'b1;
            else if (j == togLo)               dump = 1'b1;
            else if (j > togLo && j <= togHi)  dump = 1'($urandom_range(0, 1));
            else                               dump = 1'b0;
        end
    endtask

    function automatic logic exp_at(input int which, input int j);
        case (which)
            0:       return expLine[j];
            1:       return (j < T);
            default: return (j == T);
        endcase
    endfunction

    function automatic logic log_at(input int which, input int idx);
        case (which)
            0:       return lineLog[idx];
            1:       return busyLog[idx];
            default: return doneLog[idx];
        endcase
    endfunction

    // which: 0 = tx, 1 = busy, 2 = done. Returns first deviating j or -1.
    function automatic int first_diff(input int which, input int offset, input int n);
        for (int j = 0; j < n; j++)
            if (log_at(which, offset + j) !== exp_at(which, j)) return j;
        return -1;
    endfunction

    // Address must run through 0..NREG-1 in order while busy.
    function automatic int addr_diff();
        int p;
        p = 0;
        if (addrLog[0] !== '0) return 0;
        for (int j = 1; j < T; j++) begin
            if (addrLog[j] !== addrLog[j-1]) begin
                p++;
                if (addrLog[j] !== AW'(p)) return j;
            end
        end
        if (p != NREG - 1) return T;
        return -1;
    endfunction

    // Independent UART decode of the recorded line, sampling mid-bit.
    task automatic decode_line(input int n, output int count);
        int j;
        int mid;
        logic [7:0] b;
        count = 0;
        j = 1;
        while (j < n) begin
            if (lineLog[j] === 1'b0 && lineLog[j-1] === 1'b1) begin
                mid = j + CPB / 2;
                if (mid + CPB * 9 >= n) break;
                for (int i = 0; i < 8; i++) b[i] = lineLog[mid + CPB * (i + 1)];
                if (count < NBYTES) gotBytes[count] = b;
                count++;
                j = mid + CPB * 9;
            end else begin
                j++;
            end
        end
    endtask

    task automatic check_diff(input string name, input int which, input int offset, input int n);
        int d;
        d = first_diff(which, offset, n);
        checks++;
        if (d !== -1) begin
            failures++;
            $display("[TB] FAIL %s: sample %0d got %b expected %b", name, d,
                     log_at(which, offset + d), exp_at(which, d));
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        dump  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 3) dump = 1'b1;
        end
        checks++; if (tx !== 1'b1)   begin failures++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (memAddr !== '0) begin failures++; $display("[TB] FAIL reset_addr: got %0d expected 0", memAddr); end
        reset = 1'b0;
        dump  = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL reset_no_frame: got %0d active samples expected 0", bad); end
    endtask

    task automatic test_full_dump();
        int d;
        randomize_mem();
        build_model();
        dump = 1'b1;
        record_dump(T + 2, 1'b0, -1, -2);
        checks++; if (lineLog[2] !== 1'b1) begin failures++; $display("[TB] FAIL lead_high: got %b expected 1", lineLog[2]); end
        checks++; if (lineLog[3] !== 1'b0) begin failures++; $display("[TB] FAIL start_edge: got %b expected 0", lineLog[3]); end
        check_diff("full_tx", 0, 0, T + 1);
        check_diff("full_busy", 1, 0, T + 1);
        check_diff("full_done", 2, 0, T + 1);
        d = addr_diff();
        checks++; if (d !== -1) begin failures++; $display("[TB] FAIL full_addr_seq: deviates at sample %0d got %0d", d, addrLog[d < T ? d : T-1]); end
        checks++; if (doneLog[T+1] !== 1'b0) begin failures++; $display("[TB] FAIL done_width: got %b expected 0", doneLog[T+1]); end
    endtask

    task automatic test_known_pattern();
        logic [7:0] known [NBYTES];
        int n;
        known = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        for (int i = 0; i < NREG; i++) mem[i] = RW'(i);
        build_model();
        dump = 1'b1;
        record_dump(T + 1, 1'b0, -1, -2);
        check_diff("known_tx", 0, 0, T + 1);
        decode_line(T + 1, n);
        checks++; if (n != NBYTES) begin failures++; $display("[TB] FAIL known_count: got %0d expected %0d", n, NBYTES); end
        for (int k = 0; k < NBYTES && k < n; k++) begin
            checks++;
            if (gotBytes[k] !== known[k]) begin
                failures++;
                $display("[TB] FAIL known_byte%0d: got %h expected %h", k, gotBytes[k], known[k]);
            end
        end
    endtask

    task automatic test_busy_retrigger();
        int s3;
        int nDone;
        int n;
        randomize_mem();
        build_model();
        s3 = 3 + 3 * (10 * CPB + 2);
        dump = 1'b1;
        record_dump(T + 4, 1'b0, s3 + 1, s3 + 10 * CPB - 2);
        check_diff("retrig_tx", 0, 0, T + 1);
        nDone = 0;
        for (int j = 0; j < T + 4; j++) if (doneLog[j] === 1'b1) nDone++;
        checks++; if (nDone != 1) begin failures++; $display("[TB] FAIL retrig_done_count: got %0d expected 1", nDone); end
        decode_line(T + 1, n);
        for (int k = 0; k < NBYTES; k++) begin
            checks++;
            if (k >= n || gotBytes[k] !== expBytes[k]) begin
                failures++;
                $display("[TB] FAIL retrig_byte%0d: got %h expected %h", k, k < n ? gotBytes[k] : 8'hxx, expBytes[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        randomize_mem();
        build_model();
        dump = 1'b1;
        record_dump(2 * T + 2, 1'b1, -1, -2);
        dump = 1'b0;
        check_diff("b2b_first_tx", 0, 0, T);
        check_diff("b2b_first_busy", 1, 0, T + 1);
        checks++; if (doneLog[T] !== 1'b1)   begin failures++; $display("[TB] FAIL b2b_first_done: got %b expected 1", doneLog[T]); end
        checks++; if (busyLog[T+1] !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart: got %b expected 1", busyLog[T+1]); end
        check_diff("b2b_second_tx", 0, T + 1, T + 1);
        check_diff("b2b_second_done", 2, T + 1, T + 1);
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_busy: got %b expected 0", busy); end
        checks++; if (tx !== 1'b1)   begin failures++; $display("[TB] FAIL b2b_idle_tx: got %b expected 1", tx); end
    endtask

    task automatic test_reset_mid_frame();
        int jr;
        int bad;
        int d;
        randomize_mem();
        build_model();
        jr = 3 + 2 * (10 * CPB + 2) + CPB * 4 + 1;
        dump = 1'b1;
        record_dump(jr + 1, 1'b0, -1, -2);
        checks++; if (lineLog[jr] !== expBytes[2][3]) begin failures++; $display("[TB] FAIL mid_bit_level: got %b expected %b", lineLog[jr], expBytes[2][3]); end
        reset = 1'b1;
        step();
        checks++; if (tx !== 1'b1)    begin failures++; $display("[TB] FAIL midrst_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)  begin failures++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        checks++; if (memAddr !== '0) begin failures++; $display("[TB] FAIL midrst_addr: got %0d expected 0", memAddr); end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL midrst_quiet: got %0d active samples expected 0", bad); end
        randomize_mem();
        build_model();
        dump = 1'b1;
        record_dump(T + 1, 1'b0, -1, -2);
        check_diff("midrst_redump_tx", 0, 0, T + 1);
        check_diff("midrst_redump_done", 2, 0, T + 1);
        d = addr_diff();
        checks++; if (d !== -1) begin failures++; $display("[TB] FAIL midrst_addr_seq: deviates at sample %0d", d); end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) mem[i] = '0;
        test_reset();
        test_full_dump();
        test_known_pattern();
        test_busy_retrigger();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
